// File: rtl/maxnet_pkg.sv
// Shared MaxNet constants and the ReLU clamp used by
// the datapath, memory and writeback blocks.
package maxnet_pkg;

  localparam int MAXNET_WIDTH = 5;
  localparam int MAXNET_N = 4;
  localparam int ITER_W = 4;
  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  // Operates on a zero-extended w-bit value.
  function automatic logic [31:0] relu(
    input logic [31:0] v,
    input int w
  );
    return v[w-1] ? 32'd0 : v;
  endfunction

endpackage

// File: rtl/maxnet_status.sv
// Popcount of active entries and lowest-index
// priority encoder over an activation vector.
module maxnet_status
  import maxnet_pkg::*;
#(
  parameter int WIDTH = MAXNET_WIDTH,
  parameter int N = MAXNET_N
) (
  input  logic [N*WIDTH-1:0] x,
  output logic [2:0]         active_cnt,
  output logic [1:0]         winner_idx,
  output logic               converged,
  output logic               dead
);

  logic [WIDTH-1:0] v;
  logic [2:0]       cnt;
  logic [1:0]       win;

  always_comb begin
    v = '0;
    cnt = '0;
    win = '0;
    // Descending scan so the lowest active index wins.
    for (int i = N - 1; i >= 0; i--) begin
      v = x[i*WIDTH +: WIDTH];
      if (!v[WIDTH-1] && (|v)) begin
        cnt = cnt + 3'd1;
        win = 2'(i);
      end
    end
  end

  assign active_cnt = cnt;
  assign winner_idx = win;
  assign converged = (cnt == 3'd1);
  assign dead = (cnt == 3'd0);

endmodule

// File: rtl/x_writeback.sv
// Double-banked activation store: shadow collects a
// sweep's writes, commit publishes them to the active bank.
module x_writeback
  import maxnet_pkg::*;
#(
  parameter int WIDTH = MAXNET_WIDTH,
  parameter int N = MAXNET_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [N*WIDTH-1:0] X_in,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               commit,
  output logic [N*WIDTH-1:0] X_out,
  output logic [2:0]         active_cnt,
  output logic               converged,
  output logic               dead,
  output logic [1:0]         winner_idx,
  output logic [3:0]         iter_cnt,
  output logic               timeout
);

  logic [WIDTH-1:0] shadow_q [N];
  logic [WIDTH-1:0] shadow_d [N];
  logic [WIDTH-1:0] active_q [N];
  logic [WIDTH-1:0] active_d [N];
  logic [3:0]       iter_q;
  logic [3:0]       iter_d;

  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH-1:0] v
  );
    logic [31:0] r;
    r = relu(32'(v), WIDTH);
    return r[WIDTH-1:0];
  endfunction

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    iter_d = iter_q;
    if (load) begin
      for (int i = 0; i < N; i++) begin
        shadow_d[i] = clamp(X_in[i*WIDTH +: WIDTH]);
        active_d[i] = clamp(X_in[i*WIDTH +: WIDTH]);
      end
      iter_d = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_en && (wr_idx == 2'(i))) begin
          shadow_d[i] = clamp(wr_data);
        end
      end
      // Same-cycle write is folded into the commit.
      if (commit) begin
        active_d = shadow_d;
        if (iter_q != ITER_MAX) begin
          iter_d = iter_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      iter_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      iter_q <= iter_d;
    end
  end

  always_comb begin
    X_out = '0;
    for (int i = 0; i < N; i++) begin
      X_out[i*WIDTH +: WIDTH] = active_q[i];
    end
  end

  assign iter_cnt = iter_q;
  assign timeout = (iter_q == ITER_MAX);

  maxnet_status #(
    .WIDTH(WIDTH),
    .N(N)
  ) u_status (
    .x(X_out),
    .active_cnt(active_cnt),
    .winner_idx(winner_idx),
    .converged(converged),
    .dead(dead)
  );

endmodule

// File: doc/x_writeback.md
X_WRITEBACK -- requirements
Module: x_writeback

Interface
REQ-001 SHALL have parameter WIDTH, default 5, bit width of one signed two's-complement activation value.
REQ-002 SHALL have parameter N, default 4, number of neurons and activation entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port load, input, 1, one-cycle pulse that loads the initial vector from X_in.
REQ-006 SHALL have port X_in, input, N x WIDTH, the initial activation vector from the memory block.
REQ-007 SHALL have port wr_en, input, 1, write strobe into the shadow bank.
REQ-008 SHALL have port wr_idx, input, 2, shadow-bank write index.
REQ-009 SHALL have port wr_data, input, WIDTH, signed new activation value.
REQ-010 SHALL have port commit, input, 1, end-of-sweep pulse that copies the shadow bank to the active bank.
REQ-011 SHALL have port X_out, output, N x WIDTH, the active bank, fed back to the datapath.
REQ-012 SHALL have port active_cnt, output, 3, number of active entries (value > 0).
REQ-013 SHALL have port converged, output, 1, high when active_cnt == 1.
REQ-014 SHALL have port dead, output, 1, high when active_cnt == 0.
REQ-015 SHALL have port winner_idx, output, 2, lowest index with value > 0; 0 when none.
REQ-016 SHALL have port iter_cnt, output, 4, number of commits since the last load.
REQ-017 SHALL have port timeout, output, 1, high when iter_cnt == 15.

Function
REQ-018 SHALL store every value clamped by ReLU: if the sign bit is 1, 0 is stored; otherwise the value is stored unchanged.
REQ-019 SHALL, on load, write clamp(X_in[i]) into both the active and shadow banks for all i, and set iter_cnt to 0.
REQ-020 SHALL ignore wr_en and commit in any cycle where load is high.
REQ-021 SHALL, on wr_en without load, write clamp(wr_data) into shadow[wr_idx]; the active bank is unchanged.
REQ-022 SHALL, on commit without load, copy the shadow bank into the active bank; this gives synchronous MaxNet update semantics.
REQ-023 SHALL, when wr_en and commit occur in the same cycle, include that cycle's write in the committed vector.
REQ-024 SHALL, on each commit, increment iter_cnt, saturating at 15 with no wrap.
REQ-025 SHALL keep the shadow bank equal to the committed value after a commit, until the next write.
REQ-026 SHALL derive active_cnt, converged, dead and winner_idx combinationally from the active bank, so they are valid in the cycle after the load or commit edge.
REQ-027 SHALL make X_out show an updated entry in the cycle after the load or commit edge; there is no combinational path from wr_data to X_out.
REQ-028 SHALL treat the value 0 as inactive; the most negative input value (10000) clamps to 0.
REQ-029 SHALL apply the priority order rst > load > (wr_en, commit).

Reset
REQ-030 SHALL, on rst at a clock edge, clear both banks to 0 and set iter_cnt to 0.
REQ-031 SHALL, in the cycle after reset, drive X_out = 0, active_cnt = 0, dead = 1, converged = 0, winner_idx = 0, timeout = 0.
REQ-032 SHALL, when rst is asserted mid-sweep, discard all pending shadow writes; a commit in the same cycle has no effect.

Structure
REQ-033 SHALL place WIDTH, N, the iteration-counter width and the ReLU clamp function in the shared package maxnet_pkg, which the datapath and memory blocks also use.
REQ-034 SHALL implement the popcount and lowest-index priority encoder as the sub-module maxnet_status, with input an N x WIDTH vector and outputs active_cnt, winner_idx, converged and dead.
REQ-035 SHALL contain no memories inferred from file initialisation; all state is reset-controlled registers.

Verification
REQ-036 SHALL cover: reset, then load X_in = {00110, 00011, 00101, 00001} -> next cycle X_out matches X_in, active_cnt = 4, converged = 0, iter_cnt = 0.
REQ-037 SHALL cover: after load, write idx1 = 11101 and idx3 = 11110 with no commit -> X_out unchanged; then commit -> X_out = {00110, 00000, 00101, 00000}, active_cnt = 2, iter_cnt = 1.
REQ-038 SHALL cover: write idx2 = 11111 in the same cycle as commit, from the state in REQ-037 -> X_out[2] = 0, converged = 1, winner_idx = 0, active_cnt = 1.
REQ-039 SHALL cover: 16 commits without load -> iter_cnt stops at 15, timeout = 1; then load -> iter_cnt = 0, timeout = 0.
REQ-040 SHALL cover: load with X_in all negative {10000, 11111, 10101, 11000} -> X_out = 0, dead = 1, winner_idx = 0.
REQ-041 SHALL cover: assert load, wr_en (idx0 = 01111) and commit in the same cycle -> X_out = clamp(X_in), iter_cnt = 0; assert rst in the same cycle as commit -> all outputs at reset values.
